// File: rtl/riscv_bp_pkg.sv
// Shared types and constants for the correlating branch predictor: 2-bit counter
// encoding, taken decode and sequential PC increments.
package riscv_bp_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_ST  = 2'b10,
        BP_WT  = 2'b11
    } bp_state_t;

    localparam int unsigned RVC_INC = 2;
    localparam int unsigned RVI_INC = 4;

    // The MSB of the counter is the direction; the LSB is only hysteresis.
    function automatic logic bp_is_taken(input bp_state_t state);
        return state[1];
    endfunction

endpackage

// File: rtl/riscv_bp_ghr.sv
// Global history register: shifts one resolved outcome in per update, newest bit at LSB.
module riscv_bp_ghr #(
    parameter int unsigned BP_GLOBAL_BITS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      shift_i,
    input  logic                      bit_i,
    output logic [BP_GLOBAL_BITS-1:0] history_o
);

    logic [BP_GLOBAL_BITS-1:0] ghr_q;

    generate
        if (BP_GLOBAL_BITS == 1) begin : g_one_bit
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ghr_q <= '0;
                end else if (shift_i) begin
                    ghr_q <= bit_i;
                end
            end
        end else begin : g_multi_bit
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ghr_q <= '0;
                end else if (shift_i) begin
                    ghr_q <= {ghr_q[BP_GLOBAL_BITS-2:0], bit_i};
                end
            end
        end
    endgenerate

    assign history_o = ghr_q;

endmodule

// File: rtl/riscv_bu_bp_update.sv
// Branch-resolution side of the predictor: tracks ID predictions into EX, drives the predictor
// write port, owns the GHR and flags mispredicts. Optional counters under `BP_STATS_EN`.
module riscv_bu_bp_update
    import riscv_bp_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned HAS_BPU        = 1,
    parameter int unsigned BP_GLOBAL_BITS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      id_valid_i,
    input  logic [1:0]                id_bp_predict_i,
    input  logic                      ex_stall_i,
    input  logic                      ex_flush_i,
    input  logic [XLEN-1:0]           ex_pc_i,
    input  logic                      ex_is_branch_i,
    input  logic                      ex_is_rvc_i,
    input  logic                      ex_btaken_i,
    input  logic [XLEN-1:0]           ex_target_i,
    output logic                      bu_bp_update_o,
    output logic [1:0]                bu_bp_predict_o,
    output logic                      bu_bp_btaken_o,
    output logic [BP_GLOBAL_BITS-1:0] bu_bp_history_o,
    output logic [XLEN-1:0]           bu_bp_pc_o,
    output logic                      bu_mispredict_o,
`ifdef BP_STATS_EN
    output logic [31:0]               bu_stat_branches_o,
    output logic [31:0]               bu_stat_mispredicts_o,
`endif
    output logic [XLEN-1:0]           bu_redirect_pc_o
);

    localparam logic BPU_EN = (HAS_BPU != 0);

    logic            ex_valid_q;
    logic [1:0]      ex_predict_q;
    logic [1:0]      predict_d;
    logic            fire;
    logic            mispredict_d;
    logic [XLEN-1:0] redirect_d;

    logic            update_q;
    logic [1:0]      predict_q;
    logic            btaken_q;
    logic [XLEN-1:0] pc_q;
    logic            mispredict_q;
    logic [XLEN-1:0] redirect_q;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        predict_d    = 2'b00;
        mispredict_d = 1'b0;
        redirect_d   = '0;
        if (BPU_EN) begin
            predict_d = id_bp_predict_i;
        end
        // Without a BPU the prediction is forced to SNT, so any taken branch mispredicts.
        mispredict_d = bp_is_taken(bp_state_t'(ex_predict_q)) ^ ex_btaken_i;
        if (ex_btaken_i) begin
            redirect_d = ex_target_i;
        end else begin
            redirect_d = ex_pc_i + (ex_is_rvc_i ? XLEN'(RVC_INC) : XLEN'(RVI_INC));
        end
    end

    assign fire = ex_valid_q & ex_is_branch_i & ~ex_stall_i & ~ex_flush_i;

    // NOTE: only control and pipeline registers here, no storage arrays, so every flop takes the async reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q   <= 1'b0;
            ex_predict_q <= 2'b00;
        end else begin
            if (ex_flush_i) begin
                ex_valid_q <= 1'b0;
            end else if (!ex_stall_i) begin
                ex_valid_q <= id_valid_i;
            end
            if (!ex_stall_i) begin
                ex_predict_q <= predict_d;
            end
        end
    end

    // The write-port payload holds between updates; only update/mispredict pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
            predict_q    <= 2'b00;
            btaken_q     <= 1'b0;
            pc_q         <= '0;
            redirect_q   <= '0;
        end else begin
            update_q     <= fire & BPU_EN;
            mispredict_q <= fire & mispredict_d;
            if (fire) begin
                predict_q  <= ex_predict_q;
                btaken_q   <= ex_btaken_i;
                pc_q       <= ex_pc_i;
                redirect_q <= redirect_d;
            end
        end
    end

    // Shifting at the edge that ends the update cycle keeps read and write indices aligned.
    riscv_bp_ghr #(
        .BP_GLOBAL_BITS(BP_GLOBAL_BITS)
    ) u_ghr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .shift_i  (update_q),
        .bit_i    (btaken_q),
        .history_o(bu_bp_history_o)
    );

    assign bu_bp_update_o   = update_q;
    assign bu_bp_predict_o  = predict_q;
    assign bu_bp_btaken_o   = btaken_q;
    assign bu_bp_pc_o       = pc_q;
    assign bu_mispredict_o  = mispredict_q;
    assign bu_redirect_pc_o = redirect_q;

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q;
    logic [31:0] stat_mispredicts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (update_q && (stat_branches_q != 32'hFFFF_FFFF)) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (mispredict_q && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
        end
    end

    assign bu_stat_branches_o    = stat_branches_q;
    assign bu_stat_mispredicts_o = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_riscv_bu_bp_update.sv
// Directed bench for riscv_bu_bp_update: table of single-branch vectors plus hand-written
// back-to-back, stall, flush and reset-during-update sequences.
module tb_riscv_bu_bp_update;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        id_valid_i;
    logic [1:0]  id_bp_predict_i;
    logic        ex_stall_i;
    logic        ex_flush_i;
    logic [31:0] ex_pc_i;
    logic        ex_is_branch_i;
    logic        ex_is_rvc_i;
    logic        ex_btaken_i;
    logic [31:0] ex_target_i;
    logic        bu_bp_update_o;
    logic [1:0]  bu_bp_predict_o;
    logic        bu_bp_btaken_o;
    logic [1:0]  bu_bp_history_o;
    logic [31:0] bu_bp_pc_o;
    logic        bu_mispredict_o;
    logic [31:0] bu_redirect_pc_o;
`ifdef BP_STATS_EN
    logic [31:0] bu_stat_branches_o;
    logic [31:0] bu_stat_mispredicts_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    riscv_bu_bp_update #(
        .XLEN(32), .HAS_BPU(1), .BP_GLOBAL_BITS(2)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .id_valid_i           (id_valid_i),
        .id_bp_predict_i      (id_bp_predict_i),
        .ex_stall_i           (ex_stall_i),
        .ex_flush_i           (ex_flush_i),
        .ex_pc_i              (ex_pc_i),
        .ex_is_branch_i       (ex_is_branch_i),
        .ex_is_rvc_i          (ex_is_rvc_i),
        .ex_btaken_i          (ex_btaken_i),
        .ex_target_i          (ex_target_i),
        .bu_bp_update_o       (bu_bp_update_o),
        .bu_bp_predict_o      (bu_bp_predict_o),
        .bu_bp_btaken_o       (bu_bp_btaken_o),
        .bu_bp_history_o      (bu_bp_history_o),
        .bu_bp_pc_o           (bu_bp_pc_o),
        .bu_mispredict_o      (bu_mispredict_o),
`ifdef BP_STATS_EN
        .bu_stat_branches_o   (bu_stat_branches_o),
        .bu_stat_mispredicts_o(bu_stat_mispredicts_o),
`endif
        .bu_redirect_pc_o     (bu_redirect_pc_o)
    );

    typedef struct {
        logic [1:0]  predict;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        rvc;
        logic        exp_mispredict;
        logic [31:0] exp_redirect;
        logic [1:0]  exp_hist;
        logic [1:0]  exp_hist_after;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_valid_i      = 1'b0;
        id_bp_predict_i = 2'b00;
        ex_stall_i      = 1'b0;
        ex_flush_i      = 1'b0;
        ex_pc_i         = '0;
        ex_is_branch_i  = 1'b0;
        ex_is_rvc_i     = 1'b0;
        ex_btaken_i     = 1'b0;
        ex_target_i     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Issue one branch through ID then EX; checks the update cycle and the cycle after.
    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk_i);
        id_valid_i      = 1'b1;
        id_bp_predict_i = v.predict;
        @(negedge clk_i);
        id_valid_i      = 1'b0;
        id_bp_predict_i = 2'b00;
        ex_is_branch_i  = 1'b1;
        ex_pc_i         = v.pc;
        ex_btaken_i     = v.taken;
        ex_target_i     = v.target;
        ex_is_rvc_i     = v.rvc;
        @(negedge clk_i);
        check({tag, "_update"},     32'(bu_bp_update_o),  32'd1);
        check({tag, "_predict"},    32'(bu_bp_predict_o), 32'(v.predict));
        check({tag, "_btaken"},     32'(bu_bp_btaken_o),  32'(v.taken));
        check({tag, "_pc"},         bu_bp_pc_o,           v.pc);
        check({tag, "_history"},    32'(bu_bp_history_o), 32'(v.exp_hist));
        check({tag, "_mispredict"}, 32'(bu_mispredict_o), 32'(v.exp_mispredict));
        check({tag, "_redirect"},   bu_redirect_pc_o,     v.exp_redirect);
        ex_is_branch_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_update_drop"}, 32'(bu_bp_update_o),  32'd0);
        check({tag, "_mis_drop"},    32'(bu_mispredict_o), 32'd0);
        check({tag, "_hist_after"},  32'(bu_bp_history_o), 32'(v.exp_hist_after));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Predictor encoding: 00 SNT, 01 WNT, 11 WT, 10 ST; MSB = predicted taken.
        vecs[0] = '{2'b01, 32'h0000_0100, 1'b1, 32'h0000_0180, 1'b0, 1'b1, 32'h0000_0180, 2'b00, 2'b01};
        vecs[1] = '{2'b11, 32'h0000_0200, 1'b1, 32'h0000_0240, 1'b0, 1'b0, 32'h0000_0240, 2'b01, 2'b11};
        vecs[2] = '{2'b00, 32'h0000_0300, 1'b0, 32'h0000_0999, 1'b0, 1'b0, 32'h0000_0304, 2'b11, 2'b10};
        vecs[3] = '{2'b10, 32'h0000_0400, 1'b0, 32'h0000_0888, 1'b1, 1'b1, 32'h0000_0402, 2'b10, 2'b00};
        vecs[4] = '{2'b10, 32'hFFFF_FFFE, 1'b0, 32'h0000_1234, 1'b1, 1'b1, 32'h0000_0000, 2'b00, 2'b00};

        idle_inputs();
        rst_ni = 1'b0;
        #12;
        rst_ni = 1'b1;

        // Reset state, and nothing happens without branches.
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst_update",     32'(bu_bp_update_o),  32'd0);
        check("rst_predict",    32'(bu_bp_predict_o), 32'd0);
        check("rst_btaken",     32'(bu_bp_btaken_o),  32'd0);
        check("rst_history",    32'(bu_bp_history_o), 32'd0);
        check("rst_pc",         bu_bp_pc_o,           32'd0);
        check("rst_mispredict", 32'(bu_mispredict_o), 32'd0);
        check("rst_redirect",   bu_redirect_pc_o,     32'd0);
`ifdef BP_STATS_EN
        check("rst_stat_br",  bu_stat_branches_o,    32'd0);
        check("rst_stat_mis", bu_stat_mispredicts_o, 32'd0);
`endif

        for (int i = 0; i < 5; i++) begin
            run_vec(i, vecs[i]);
        end
`ifdef BP_STATS_EN
        check("stat_branches",    bu_stat_branches_o,    32'd5);
        check("stat_mispredicts", bu_stat_mispredicts_o, 32'd3);
`endif

        // Three back-to-back taken branches: history 00, 01, 11 in the update cycles.
        do_reset();
        begin
            logic [1:0] exp_hist[3];
            exp_hist[0] = 2'b00;
            exp_hist[1] = 2'b01;
            exp_hist[2] = 2'b11;
            @(negedge clk_i);
            id_valid_i      = 1'b1;
            id_bp_predict_i = 2'b11;
            @(negedge clk_i);
            ex_is_branch_i = 1'b1;
            ex_btaken_i    = 1'b1;
            ex_pc_i        = 32'h0000_0500;
            ex_target_i    = 32'h0000_0600;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                check($sformatf("b2b%0d_update", i),     32'(bu_bp_update_o),  32'd1);
                check($sformatf("b2b%0d_history", i),    32'(bu_bp_history_o), 32'(exp_hist[i]));
                check($sformatf("b2b%0d_mispredict", i), 32'(bu_mispredict_o), 32'd0);
                check($sformatf("b2b%0d_pc", i),         bu_bp_pc_o,           32'h0000_0500 + 32'(4 * i));
                ex_pc_i = ex_pc_i + 32'd4;
                if (i == 1) id_valid_i = 1'b0;
                if (i == 2) ex_is_branch_i = 1'b0;
            end
            @(negedge clk_i);
            check("b2b_update_drop", 32'(bu_bp_update_o),  32'd0);
            check("b2b_hist_final",  32'(bu_bp_history_o), 32'b11);
        end

        // Stall for three cycles: exactly one update, after release.
        do_reset();
        @(negedge clk_i);
        id_valid_i      = 1'b1;
        id_bp_predict_i = 2'b11;
        @(negedge clk_i);
        id_valid_i     = 1'b0;
        ex_is_branch_i = 1'b1;
        ex_btaken_i    = 1'b1;
        ex_pc_i        = 32'h0000_0700;
        ex_target_i    = 32'h0000_0740;
        ex_stall_i     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("stall%0d_update", i), 32'(bu_bp_update_o), 32'd0);
        end
        ex_stall_i = 1'b0;
        @(negedge clk_i);
        check("stall_release_update", 32'(bu_bp_update_o), 32'd1);
        check("stall_release_pc",     bu_bp_pc_o,           32'h0000_0700);
        @(negedge clk_i);
        check("stall_single_pulse", 32'(bu_bp_update_o),  32'd0);
        check("stall_hist_after",   32'(bu_bp_history_o), 32'b01);
        ex_is_branch_i = 1'b0;

        // Flush with a branch in EX: no update, no mispredict, GHR unchanged.
        @(negedge clk_i);
        id_valid_i      = 1'b1;
        id_bp_predict_i = 2'b00;
        @(negedge clk_i);
        id_valid_i     = 1'b0;
        ex_is_branch_i = 1'b1;
        ex_btaken_i    = 1'b1;
        ex_pc_i        = 32'h0000_0800;
        ex_target_i    = 32'h0000_0900;
        ex_flush_i     = 1'b1;
        @(negedge clk_i);
        ex_flush_i = 1'b0;
        check("flush_update0",     32'(bu_bp_update_o),  32'd0);
        check("flush_mispredict0", 32'(bu_mispredict_o), 32'd0);
        @(negedge clk_i);
        check("flush_update1",     32'(bu_bp_update_o),  32'd0);
        check("flush_mispredict1", 32'(bu_mispredict_o), 32'd0);
        check("flush_history",     32'(bu_bp_history_o), 32'b01);
        ex_is_branch_i = 1'b0;

        // Reset asserted during an update cycle drops the pulse and clears the GHR at once.
        @(negedge clk_i);
        id_valid_i      = 1'b1;
        id_bp_predict_i = 2'b01;
        @(negedge clk_i);
        id_valid_i     = 1'b0;
        ex_is_branch_i = 1'b1;
        ex_btaken_i    = 1'b1;
        ex_pc_i        = 32'h0000_0A00;
        ex_target_i    = 32'h0000_0B00;
        @(negedge clk_i);
        ex_is_branch_i = 1'b0;
        check("rstmid_update_before", 32'(bu_bp_update_o),  32'd1);
        check("rstmid_hist_before",   32'(bu_bp_history_o), 32'b01);
        #1;
        rst_ni = 1'b0;
        #1;
        check("rstmid_update",     32'(bu_bp_update_o),  32'd0);
        check("rstmid_history",    32'(bu_bp_history_o), 32'd0);
        check("rstmid_mispredict", 32'(bu_mispredict_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rstmid_post_update",  32'(bu_bp_update_o),  32'd0);
        check("rstmid_post_history", 32'(bu_bp_history_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
